// File: rtl/param_set_store_pkg.sv
// Shared constants for the SPS/PPS store: field codes, FSM encodings and entry layouts.
// Entry layout depends on PS_HIGH_PROFILE_EN (chroma_format_idc storage in the SPS).
package param_set_store_pkg;

    localparam logic [4:0] PS_F_PROFILE    = 5'd0;
    localparam logic [4:0] PS_F_LEVEL      = 5'd1;
    localparam logic [4:0] PS_F_SPS_ID     = 5'd2;
    localparam logic [4:0] PS_F_LOG2_FN    = 5'd3;
    localparam logic [4:0] PS_F_POC_TYPE   = 5'd4;
    localparam logic [4:0] PS_F_CHROMA_FMT = 5'd5;
    localparam logic [4:0] PS_F_WIDTH      = 5'd6;
    localparam logic [4:0] PS_F_HEIGHT     = 5'd7;
    localparam logic [4:0] PS_F_PPS_ID     = 5'd8;
    localparam logic [4:0] PS_F_PPS_SPS_ID = 5'd9;
    localparam logic [4:0] PS_F_WBIPRED    = 5'd10;
    localparam logic [4:0] PS_F_QP26       = 5'd11;
    localparam logic [4:0] PS_F_CQP_OFS    = 5'd12;
    localparam logic [4:0] PS_F_DBF_CIP    = 5'd13;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LOOKUP_PPS = 2'd1;
    localparam logic [1:0] ST_LOOKUP_SPS = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    // SPS entry, MSB first: [chroma(2)], profile(8), log2_fn(4), poc_type(2), width, height
`ifdef PS_HIGH_PROFILE_EN
    localparam int unsigned SPS_FIXED_W = 16;
`else
    localparam int unsigned SPS_FIXED_W = 14;
`endif

    // PPS entry bit offsets
    localparam int unsigned PPS_CIP_OFS    = 0;
    localparam int unsigned PPS_DBF_OFS    = 1;
    localparam int unsigned PPS_WB_OFS     = 2;
    localparam int unsigned PPS_CQP_OFS    = 4;
    localparam int unsigned PPS_QP26_OFS   = 9;
    localparam int unsigned PPS_SPS_ID_OFS = 15;
    localparam int unsigned PPS_W          = 23;

    function automatic int unsigned sps_entry_w(input int unsigned mbw);
        return SPS_FIXED_W + 2 * mbw;
    endfunction

`ifdef PS_HIGH_PROFILE_EN
    function automatic logic is_high_profile(input logic [7:0] p);
        return (p == 8'd100) || (p == 8'd110) || (p == 8'd122) || (p == 8'd244);
    endfunction
`endif

endpackage

// File: rtl/ps_table.sv
// Parameter-set table: DEPTH entries of W bits with valid bits,
// one synchronous write port and one combinational read port.
module ps_table #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is never observed without its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/param_set_store.sv
// Multi-entry SPS/PPS store with slice-header activation FSM.
// Build option PS_HIGH_PROFILE_EN adds chroma_format_idc storage to the SPS.
module param_set_store
    import param_set_store_pkg::*;
#(
    parameter int unsigned NUM_SPS = 4,
    parameter int unsigned NUM_PPS = 8,
    parameter int unsigned MBW     = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           fld_valid,
    input  logic [4:0]     fld_sel,
    input  logic [15:0]    fld_data,
    input  logic           sps_commit,
    input  logic           pps_commit,
    output logic           commit_err,
    input  logic           act_req,
    input  logic [7:0]     act_pps_id,
    output logic           act_ready,
    output logic           act_done,
    output logic           act_err,
    output logic           active_valid,
    output logic [7:0]     profile_idc,
    output logic [1:0]     chroma_format_idc,
    output logic [3:0]     log2_max_frame_num_minus4,
    output logic [1:0]     pic_order_cnt_type,
    output logic [MBW-1:0] pic_width_in_mbs_minus1,
    output logic [MBW-1:0] pic_height_in_map_units_minus1,
    output logic [5:0]     pic_init_qp_minus26,
    output logic [4:0]     chroma_qp_index_offset,
    output logic [1:0]     weighted_bipred_idc,
    output logic           deblocking_filter_control_present_flag,
    output logic           constrained_intra_pred_flag
);

    localparam int unsigned SPS_W   = sps_entry_w(MBW);
    localparam int unsigned SPS_IW  = (NUM_SPS > 1) ? $clog2(NUM_SPS) : 1;
    localparam int unsigned PPS_IW  = (NUM_PPS > 1) ? $clog2(NUM_PPS) : 1;
    localparam logic [8:0]  SPS_LIM = 9'(NUM_SPS);
    localparam logic [8:0]  PPS_LIM = 9'(NUM_PPS);

    logic [7:0]     sh_profile_q, sh_sps_id_q, sh_pps_id_q, sh_pps_sps_id_q;
    logic [3:0]     sh_log2_fn_q;
    logic [1:0]     sh_poc_type_q, sh_wbipred_q;
    logic [MBW-1:0] sh_width_q, sh_height_q;
    logic [5:0]     sh_qp26_q;
    logic [4:0]     sh_cqp_ofs_q;
    logic           sh_dbf_q, sh_cip_q;
`ifdef PS_HIGH_PROFILE_EN
    logic [1:0]     sh_chroma_q;
`endif

    // Level is accepted but not stored; upper data bits are truncated per field.
    logic unused_fld_data;
    assign unused_fld_data = ^fld_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_profile_q    <= '0;
            sh_sps_id_q     <= '0;
            sh_pps_id_q     <= '0;
            sh_pps_sps_id_q <= '0;
            sh_log2_fn_q    <= '0;
            sh_poc_type_q   <= '0;
            sh_wbipred_q    <= '0;
            sh_width_q      <= '0;
            sh_height_q     <= '0;
            sh_qp26_q       <= '0;
            sh_cqp_ofs_q    <= '0;
            sh_dbf_q        <= 1'b0;
            sh_cip_q        <= 1'b0;
`ifdef PS_HIGH_PROFILE_EN
            sh_chroma_q     <= '0;
`endif
        end else if (fld_valid) begin
            case (fld_sel)
                PS_F_PROFILE:    sh_profile_q    <= fld_data[7:0];
                PS_F_SPS_ID:     sh_sps_id_q     <= fld_data[7:0];
                PS_F_LOG2_FN:    sh_log2_fn_q    <= fld_data[3:0];
                PS_F_POC_TYPE:   sh_poc_type_q   <= fld_data[1:0];
`ifdef PS_HIGH_PROFILE_EN
                PS_F_CHROMA_FMT: sh_chroma_q     <= fld_data[1:0];
`endif
                PS_F_WIDTH:      sh_width_q      <= fld_data[MBW-1:0];
                PS_F_HEIGHT:     sh_height_q     <= fld_data[MBW-1:0];
                PS_F_PPS_ID:     sh_pps_id_q     <= fld_data[7:0];
                PS_F_PPS_SPS_ID: sh_pps_sps_id_q <= fld_data[7:0];
                PS_F_WBIPRED:    sh_wbipred_q    <= fld_data[1:0];
                PS_F_QP26:       sh_qp26_q       <= fld_data[5:0];
                PS_F_CQP_OFS:    sh_cqp_ofs_q    <= fld_data[4:0];
                PS_F_DBF_CIP: begin
                    sh_dbf_q <= fld_data[1];
                    sh_cip_q <= fld_data[0];
                end
                default: ;
            endcase
        end
    end

    logic             sps_id_ok, pps_id_ok, sps_wr_en, pps_wr_en, commit_err_q;
    logic [SPS_W-1:0] sps_wr_data, sps_rd_data;
    logic [PPS_W-1:0] pps_wr_data, pps_rd_data;

    assign sps_id_ok = {1'b0, sh_sps_id_q} < SPS_LIM;
    assign pps_id_ok = {1'b0, sh_pps_id_q} < PPS_LIM;
    assign sps_wr_en = sps_commit && sps_id_ok;
    assign pps_wr_en = pps_commit && pps_id_ok;

`ifdef PS_HIGH_PROFILE_EN
    logic [1:0] chroma_commit;
    // Non-high profiles are always 4:2:0 regardless of the parsed value.
    assign chroma_commit = is_high_profile(sh_profile_q) ? sh_chroma_q : 2'd1;
    assign sps_wr_data   = {chroma_commit, sh_profile_q, sh_log2_fn_q, sh_poc_type_q,
                            sh_width_q, sh_height_q};
`else
    assign sps_wr_data   = {sh_profile_q, sh_log2_fn_q, sh_poc_type_q, sh_width_q, sh_height_q};
`endif
    assign pps_wr_data = {sh_pps_sps_id_q, sh_qp26_q, sh_cqp_ofs_q, sh_wbipred_q, sh_dbf_q,
                          sh_cip_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_err_q <= 1'b0;
        end else begin
            commit_err_q <= (sps_commit && !sps_id_ok) || (pps_commit && !pps_id_ok);
        end
    end
    assign commit_err = commit_err_q;

    logic [1:0]       state_q, state_d;
    logic [7:0]       act_id_q, act_id_d;
    logic [PPS_W-1:0] pps_ent_q;
    logic [7:0]       ent_sps_id;
    logic             act_err_q, act_err_d, pps_load, act_load;
    logic             act_id_ok, ent_sps_ok, sps_rd_valid, pps_rd_valid;

    assign ent_sps_id = pps_ent_q[PPS_SPS_ID_OFS +: 8];
    assign act_id_ok  = {1'b0, act_id_q} < PPS_LIM;
    assign ent_sps_ok = {1'b0, ent_sps_id} < SPS_LIM;

    ps_table #(
        .DEPTH (NUM_SPS),
        .W     (SPS_W),
        .IW    (SPS_IW)
    ) u_sps_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (sps_wr_en),
        .wr_idx   (sh_sps_id_q[SPS_IW-1:0]),
        .wr_data  (sps_wr_data),
        .rd_idx   (ent_sps_id[SPS_IW-1:0]),
        .rd_data  (sps_rd_data),
        .rd_valid (sps_rd_valid)
    );

    ps_table #(
        .DEPTH (NUM_PPS),
        .W     (PPS_W),
        .IW    (PPS_IW)
    ) u_pps_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (pps_wr_en),
        .wr_idx   (sh_pps_id_q[PPS_IW-1:0]),
        .wr_data  (pps_wr_data),
        .rd_idx   (act_id_q[PPS_IW-1:0]),
        .rd_data  (pps_rd_data),
        .rd_valid (pps_rd_valid)
    );

    always_comb begin
        state_d   = state_q;
        act_id_d  = act_id_q;
        act_err_d = 1'b0;
        pps_load  = 1'b0;
        act_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (act_req) begin
                    act_id_d = act_pps_id;
                    state_d  = ST_LOOKUP_PPS;
                end
            end
            ST_LOOKUP_PPS: begin
                if (act_id_ok && pps_rd_valid) begin
                    pps_load = 1'b1;
                    state_d  = ST_LOOKUP_SPS;
                end else begin
                    act_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_LOOKUP_SPS: begin
                if (ent_sps_ok && sps_rd_valid) begin
                    act_load = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    act_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            act_id_q  <= '0;
            act_err_q <= 1'b0;
            pps_ent_q <= '0;
        end else begin
            state_q   <= state_d;
            act_id_q  <= act_id_d;
            act_err_q <= act_err_d;
            if (pps_load) begin
                pps_ent_q <= pps_rd_data;
            end
        end
    end

    assign act_ready = (state_q == ST_IDLE);
    assign act_done  = (state_q == ST_DONE);
    assign act_err   = act_err_q;

    logic [7:0]     rd_profile;
    logic [3:0]     rd_log2_fn;
    logic [1:0]     rd_poc_type;
    logic [MBW-1:0] rd_width, rd_height;
`ifdef PS_HIGH_PROFILE_EN
    logic [1:0]     rd_chroma, act_chroma_q;
    assign {rd_chroma, rd_profile, rd_log2_fn, rd_poc_type, rd_width, rd_height} = sps_rd_data;
`else
    assign {rd_profile, rd_log2_fn, rd_poc_type, rd_width, rd_height} = sps_rd_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_valid                           <= 1'b0;
            profile_idc                            <= '0;
            log2_max_frame_num_minus4              <= '0;
            pic_order_cnt_type                     <= '0;
            pic_width_in_mbs_minus1                <= '0;
            pic_height_in_map_units_minus1         <= '0;
            pic_init_qp_minus26                    <= '0;
            chroma_qp_index_offset                 <= '0;
            weighted_bipred_idc                    <= '0;
            deblocking_filter_control_present_flag <= 1'b0;
            constrained_intra_pred_flag            <= 1'b0;
`ifdef PS_HIGH_PROFILE_EN
            act_chroma_q                           <= '0;
`endif
        end else if (act_load) begin
            active_valid                           <= 1'b1;
            profile_idc                            <= rd_profile;
            log2_max_frame_num_minus4              <= rd_log2_fn;
            pic_order_cnt_type                     <= rd_poc_type;
            pic_width_in_mbs_minus1                <= rd_width;
            pic_height_in_map_units_minus1         <= rd_height;
            pic_init_qp_minus26                    <= pps_ent_q[PPS_QP26_OFS +: 6];
            chroma_qp_index_offset                 <= pps_ent_q[PPS_CQP_OFS +: 5];
            weighted_bipred_idc                    <= pps_ent_q[PPS_WB_OFS +: 2];
            deblocking_filter_control_present_flag <= pps_ent_q[PPS_DBF_OFS];
            constrained_intra_pred_flag            <= pps_ent_q[PPS_CIP_OFS];
`ifdef PS_HIGH_PROFILE_EN
            act_chroma_q                           <= rd_chroma;
`endif
        end
    end

`ifdef PS_HIGH_PROFILE_EN
    assign chroma_format_idc = act_chroma_q;
`else
    assign chroma_format_idc = 2'd1;
`endif

endmodule
